msx_slot_lookup: RTL and testbench

Parametrised slot-map and RAM-lookup table engine for the MSX memory subsystem. It loads per-page block descriptors (ref_ram, offset_ram, mapper, device, cart_num) and per-reference RAM descriptors (addr, size, ro) from the configuration byte stream. It then resolves CPU accesses (slot, subslot, page, offset) into a physical SDRAM address, attributes and protection flags through a 2-stage pipeline. Sits between the config loader and the slot/mapper logic; it replaces the fixed 4×4×4 static layout with a sized, clearable, error-checked table.

---
 rtl/msx_slot_lookup_if.sv | 39 +++
 rtl/msx_slot_lookup.sv | 220 ++++++++++++++++++++++
 tb/tb_msx_slot_lookup.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msx_slot_lookup_if.sv
// Configuration stream and lookup request/result bundle for msx_slot_lookup.
interface msx_slot_lookup_if #(
  parameter int SLOT_W = 2,
  parameter int SUB_W  = 2,
  parameter int PAGE_W = 2,
  parameter int ADDR_W = 27
);
  logic              cfg_start;
  logic              cfg_valid;
  logic [7:0]        cfg_data;
  logic              cfg_ready;
  logic              cfg_error;
  logic              table_valid;
  logic              lk_valid;
  logic [SLOT_W-1:0] lk_slot;
  logic [SUB_W-1:0]  lk_subslot;
  logic [PAGE_W-1:0] lk_page;
  logic [13:0]       lk_offset;
  logic              lk_wr;
  logic              res_valid;
  logic              res_hit;
  logic [ADDR_W-1:0] res_addr;
  logic [4:0]        res_mapper;
  logic [3:0]        res_device;
  logic              res_cart_num;
  logic              res_wr_blocked;

  modport master (
    output cfg_start, cfg_valid, cfg_data, lk_valid, lk_slot, lk_subslot, lk_page, lk_offset, lk_wr,
    input  cfg_ready, cfg_error, table_valid, res_valid, res_hit, res_addr, res_mapper, res_device,
           res_cart_num, res_wr_blocked
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, lk_valid, lk_slot, lk_subslot, lk_page, lk_offset, lk_wr,
    output cfg_ready, cfg_error, table_valid, res_valid, res_hit, res_addr, res_mapper, res_device,
           res_cart_num, res_wr_blocked
  );
endinterface

// File: rtl/msx_slot_lookup.sv
// Slot-map / RAM descriptor tables loaded from a config byte stream, with a
// 2-stage lookup pipeline resolving CPU block accesses to physical addresses.
module msx_slot_lookup #(
  parameter int SLOTS    = 4,
  parameter int SUBSLOTS = 4,
  parameter int PAGES    = 4,
  parameter int REFS     = 16,
  parameter int ADDR_W   = 27
) (
  input logic              clk21m,
  input logic              rst_n,
  msx_slot_lookup_if.slave bus
);
  localparam int N     = SLOTS * SUBSLOTS * PAGES;
  localparam int IDX_W = $clog2(N);
  localparam int REF_W = $clog2(REFS);

  typedef enum logic [2:0] {
    IDLE = 3'd0, CLEAR = 3'd1, TAG = 3'd2, BLK = 3'd3, RAM = 3'd4, ERROR = 3'd5, READY = 3'd6
  } state_t;

  typedef struct packed {
    logic [3:0] ref_ram;
    logic [1:0] offset_ram;
    logic [4:0] mapper;
    logic [3:0] device;
    logic       cart_num;
  } blk_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       size;
    logic              ro;
  } ram_t;

  blk_t blk_tab_r [N];
  ram_t ram_tab_r [REFS];

  state_t           state_r, state_s;
  logic [IDX_W-1:0] clr_idx_r;
  logic [2:0]       cnt_r;
  logic [55:0]      shift_r;
  logic             cfg_ready_r, cfg_error_r, table_valid_r;

  logic             accept_s;
  logic [63:0]      rec_s;
  blk_t             blk_new_s, blk_wdata_s;
  ram_t             ram_new_s, ram_wdata_s;
  logic             blk_bad_s, ram_bad_s;
  logic             blk_we_s, ram_we_s;
  logic [IDX_W-1:0] blk_widx_s;
  logic [REF_W-1:0] ram_widx_s;
  logic             unused_s;

  // rec_s holds the whole record with the byte being accepted on top
  assign accept_s  = bus.cfg_valid & cfg_ready_r;
  assign rec_s     = {bus.cfg_data, shift_r};
  assign blk_new_s = '{ref_ram: rec_s[47:44], offset_ram: rec_s[41:40], mapper: rec_s[52:48],
                       device: rec_s[63:60], cart_num: rec_s[56]};
  assign ram_new_s = '{addr: ADDR_W'(rec_s[39:8]), size: rec_s[55:40], ro: rec_s[56]};
  assign blk_bad_s = (32'(rec_s[39:32]) >= 32'(N)) | (32'(rec_s[47:44]) >= 32'(REFS));
  assign ram_bad_s = (32'(rec_s[7:0]) >= 32'(REFS));
  assign unused_s  = ^rec_s[59:57];

  // Loader next-state and table write-port selection
  always_comb begin
    state_s     = state_r;
    blk_we_s    = 1'b0;
    blk_widx_s  = clr_idx_r;
    blk_wdata_s = '0;
    ram_we_s    = 1'b0;
    ram_widx_s  = clr_idx_r[REF_W-1:0];
    ram_wdata_s = '0;
    if (bus.cfg_start) begin
      state_s = CLEAR;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        CLEAR: begin
          blk_we_s = 1'b1;
          ram_we_s = (32'(clr_idx_r) < 32'(REFS));
          if (clr_idx_r == IDX_W'(N - 1)) state_s = TAG;
          else state_s = CLEAR;
        end
        TAG: begin
          if (accept_s) begin
            case (bus.cfg_data)
              8'h01:   state_s = BLK;
              8'h02:   state_s = RAM;
              8'hFF:   state_s = READY;
              default: state_s = ERROR;
            endcase
          end else begin
            state_s = TAG;
          end
        end
        BLK: begin
          if (accept_s && (cnt_r == 3'd3)) begin
            if (blk_bad_s) begin
              state_s = ERROR;
            end else begin
              state_s     = TAG;
              blk_we_s    = 1'b1;
              blk_widx_s  = rec_s[32 +: IDX_W];
              blk_wdata_s = blk_new_s;
            end
          end else begin
            state_s = BLK;
          end
        end
        RAM: begin
          if (accept_s && (cnt_r == 3'd7)) begin
            if (ram_bad_s) begin
              state_s = ERROR;
            end else begin
              state_s     = TAG;
              ram_we_s    = 1'b1;
              ram_widx_s  = rec_s[0 +: REF_W];
              ram_wdata_s = ram_new_s;
            end
          end else begin
            state_s = RAM;
          end
        end
        ERROR:   state_s = ERROR;
        READY:   state_s = READY;
        default: state_s = IDLE;
      endcase
    end
  end

  // Loader state, byte counter and status flags
  always_ff @(posedge clk21m or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      clr_idx_r     <= '0;
      cnt_r         <= 3'd0;
      shift_r       <= 56'd0;
      cfg_ready_r   <= 1'b0;
      cfg_error_r   <= 1'b0;
      table_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cfg_ready_r   <= state_s inside {TAG, BLK, RAM, ERROR, READY};
      cfg_error_r   <= (state_s == ERROR);
      table_valid_r <= (state_s == READY);
      if (bus.cfg_start) clr_idx_r <= '0;
      else if (state_r == CLEAR) clr_idx_r <= clr_idx_r + IDX_W'(1);
      if (state_r == TAG) cnt_r <= 3'd0;
      else if (accept_s) cnt_r <= cnt_r + 3'd1;
      if (accept_s) shift_r <= rec_s[63:8];
    end
  end

  // Table storage: contents are only defined after a CLEAR pass
  always_ff @(posedge clk21m) begin
    if (blk_we_s) blk_tab_r[blk_widx_s] <= blk_wdata_s;
    if (ram_we_s) ram_tab_r[ram_widx_s] <= ram_wdata_s;
  end

  logic        s1_valid_r, s1_tv_r, s1_wr_r;
  blk_t        s1_blk_r;
  logic [13:0] s1_off_r;
  ram_t        ram_rd_s;
  logic [15:0] rel_s;
  logic        hit_s;

  logic              res_valid_r, res_hit_r, res_cart_r, res_wrb_r;
  logic [ADDR_W-1:0] res_addr_r;
  logic [4:0]        res_mapper_r;
  logic [3:0]        res_device_r;

  // A size of 64 KB or more makes the range compare always true
  assign ram_rd_s = ram_tab_r[s1_blk_r.ref_ram[REF_W-1:0]];
  assign rel_s    = {s1_blk_r.offset_ram, s1_off_r};
  assign hit_s    = s1_valid_r & s1_tv_r & (s1_blk_r.mapper != 5'd0) &
                    ({10'd0, rel_s[15:10]} < ram_rd_s.size);

  // Two-stage lookup: block entry read, then RAM descriptor and address add
  always_ff @(posedge clk21m or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_tv_r      <= 1'b0;
      s1_wr_r      <= 1'b0;
      s1_blk_r     <= '0;
      s1_off_r     <= 14'd0;
      res_valid_r  <= 1'b0;
      res_hit_r    <= 1'b0;
      res_addr_r   <= '0;
      res_mapper_r <= 5'd0;
      res_device_r <= 4'd0;
      res_cart_r   <= 1'b0;
      res_wrb_r    <= 1'b0;
    end else begin
      s1_valid_r   <= bus.lk_valid;
      s1_tv_r      <= table_valid_r;
      s1_wr_r      <= bus.lk_wr;
      s1_blk_r     <= blk_tab_r[{bus.lk_slot, bus.lk_subslot, bus.lk_page}];
      s1_off_r     <= bus.lk_offset;
      res_valid_r  <= s1_valid_r;
      res_hit_r    <= hit_s;
      res_addr_r   <= hit_s ? (ram_rd_s.addr + ADDR_W'(rel_s)) : '0;
      res_mapper_r <= hit_s ? s1_blk_r.mapper : 5'd0;
      res_device_r <= hit_s ? s1_blk_r.device : 4'd0;
      res_cart_r   <= hit_s ? s1_blk_r.cart_num : 1'b0;
      res_wrb_r    <= s1_valid_r & s1_wr_r & (ram_rd_s.ro | ~hit_s);
    end
  end

  assign bus.cfg_ready      = cfg_ready_r;
  assign bus.cfg_error      = cfg_error_r;
  assign bus.table_valid    = table_valid_r;
  assign bus.res_valid      = res_valid_r;
  assign bus.res_hit        = res_hit_r;
  assign bus.res_addr       = res_addr_r;
  assign bus.res_mapper     = res_mapper_r;
  assign bus.res_device     = res_device_r;
  assign bus.res_cart_num   = res_cart_r;
  assign bus.res_wr_blocked = res_wrb_r;
endmodule

// File: tb/tb_msx_slot_lookup.sv
// Directed + randomized bench for msx_slot_lookup against an arithmetic table model.
module tb_msx_slot_lookup;
  localparam int NE = 64;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msx_slot_lookup_if #(.SLOT_W(2), .SUB_W(2), .PAGE_W(2), .ADDR_W(27)) bus ();

  msx_slot_lookup dut (.clk21m(clk), .rst_n(rst_n), .bus(bus));

  // Reference model: plain arrays indexed by block number and ref number
  int      m_ref [NE], m_off [NE], m_map [NE], m_dev [NE], m_cart [NE];
  longint  m_addr [NR];
  int      m_size [NR], m_ro [NR];
  bit      m_tv;

  typedef struct { int s, ss, p, off; bit wr; } req_t;
  typedef struct { bit hit; longint addr; int mapper, device, cart; bit wrb; } res_t;
  req_t reqs[$];
  int   loaded[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NE; i++) begin
      m_ref[i] = 0; m_off[i] = 0; m_map[i] = 0; m_dev[i] = 0; m_cart[i] = 0;
    end
    for (int i = 0; i < NR; i++) begin
      m_addr[i] = 0; m_size[i] = 0; m_ro[i] = 0;
    end
    m_tv = 1'b0;
    loaded.delete();
  endfunction

  function automatic res_t model(req_t q);
    res_t r;
    int i, rel, rf;
    r = '{hit: 1'b0, addr: 0, mapper: 0, device: 0, cart: 0, wrb: 1'b0};
    i   = q.s * 16 + q.ss * 4 + q.p;
    rf  = m_ref[i];
    rel = m_off[i] * 16384 + q.off;
    r.hit = m_tv && (m_map[i] != 0) && ((rel / 1024) < m_size[rf]);
    if (r.hit) begin
      r.addr   = (m_addr[rf] + rel) % 134217728;
      r.mapper = m_map[i];
      r.device = m_dev[i];
      r.cart   = m_cart[i];
    end
    r.wrb = q.wr && (m_ro[rf] != 0 || !r.hit);
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = b;
    while (!bus.cfg_ready && n < 200) begin
      tick();
      n++;
    end
    chk("cfg_ready_wait", 32'(n < 200), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_ram(input int r, input int unsigned a, input int sz, input int ro);
    send_byte(8'h02);
    send_byte(8'(r));
    for (int k = 0; k < 4; k++) send_byte(8'(a >> (8 * k)));
    send_byte(8'(sz));
    send_byte(8'(sz >> 8));
    send_byte(8'(ro));
    if (r < NR) begin
      m_addr[r] = longint'(a % 134217728);
      m_size[r] = sz % 65536;
      m_ro[r]   = ro % 2;
    end
  endtask

  task automatic send_blk(input int s, ss, p, rf, off, map, dev, cart);
    int i = s * 16 + ss * 4 + p;
    send_byte(8'h01);
    send_byte(8'(i));
    send_byte(8'((rf << 4) | off));
    send_byte(8'(map));
    send_byte(8'((dev << 4) | cart));
    m_ref[i] = rf; m_off[i] = off; m_map[i] = map; m_dev[i] = dev; m_cart[i] = cart;
    loaded.push_back(i);
  endtask

  task automatic finish_load();
    send_byte(8'hFF);
    m_tv = 1'b1;
  endtask

  // Pulse cfg_start and measure how long cfg_ready stays low
  task automatic restart(input bit with_byte);
    int n = 0;
    bus.cfg_start = 1'b1;
    bus.cfg_valid = with_byte;
    bus.cfg_data  = 8'hFF;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    model_clear();
    chk("start_clears_error", 32'(bus.cfg_error), 32'd0);
    chk("start_clears_valid", 32'(bus.table_valid), 32'd0);
    while (!bus.cfg_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("clear_cycles", 32'(n), 32'd64);
  endtask

  task automatic add_req(input int s, ss, p, off, input bit wr);
    req_t q;
    q = '{s: s, ss: ss, p: p, off: off, wr: wr};
    reqs.push_back(q);
  endtask

  // Issue all queued requests back-to-back and check results two cycles later
  task automatic run_lookups();
    int k = reqs.size();
    res_t exp_q[$];
    res_t e;
    for (int t = 1; t <= k + 1; t++) begin
      if (t <= k) begin
        bus.lk_valid   = 1'b1;
        bus.lk_slot    = 2'(reqs[t-1].s);
        bus.lk_subslot = 2'(reqs[t-1].ss);
        bus.lk_page    = 2'(reqs[t-1].p);
        bus.lk_offset  = 14'(reqs[t-1].off);
        bus.lk_wr      = reqs[t-1].wr;
        exp_q.push_back(model(reqs[t-1]));
      end else begin
        bus.lk_valid = 1'b0;
        bus.lk_wr    = 1'b0;
      end
      tick();
      if (t == 1) begin
        chk("res_valid_idle", 32'(bus.res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_valid", 32'(bus.res_valid), 32'd1);
        chk("res_hit", 32'(bus.res_hit), 32'(e.hit));
        chk("res_addr", 32'(bus.res_addr), 32'(e.addr));
        chk("res_mapper", 32'(bus.res_mapper), 32'(e.mapper));
        chk("res_device", 32'(bus.res_device), 32'(e.device));
        chk("res_cart_num", 32'(bus.res_cart_num), 32'(e.cart));
        chk("res_wr_blocked", 32'(bus.res_wr_blocked), 32'(e.wrb));
      end
    end
    tick();
    chk("res_valid_drain", 32'(bus.res_valid), 32'd0);
    reqs.delete();
  endtask

  initial begin
    int idx;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = 8'h00;
    bus.lk_valid = 1'b0; bus.lk_slot = 2'd0; bus.lk_subslot = 2'd0; bus.lk_page = 2'd0;
    bus.lk_offset = 14'd0; bus.lk_wr = 1'b0;
    model_clear();
    repeat (3) tick();
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_cfg_error", 32'(bus.cfg_error), 32'd0);
    chk("rst_table_valid", 32'(bus.table_valid), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_hit", 32'(bus.res_hit), 32'd0);
    chk("rst_res_addr", 32'(bus.res_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_cfg_ready", 32'(bus.cfg_ready), 32'd0);

    // Basic mapped entry
    restart(1'b0);
    send_ram(3, 32'h0010_0000, 32, 0);
    send_blk(1, 0, 2, 3, 1, 6, 3, 0);
    chk("tv_before_ff", 32'(bus.table_valid), 32'd0);
    finish_load();
    chk("tv_after_ff", 32'(bus.table_valid), 32'd1);
    add_req(1, 0, 2, 14'h0123, 1'b0);
    add_req(1, 0, 2, 14'h0123, 1'b1);
    add_req(0, 0, 0, 14'h0000, 1'b0);
    run_lookups();
    send_byte(8'h05);
    chk("ready_discards", 32'(bus.cfg_error), 32'd0);

    // Offset 2 puts rel[15:10] exactly at size 32
    restart(1'b0);
    send_ram(3, 32'h0010_0000, 32, 0);
    send_blk(1, 0, 2, 3, 2, 6, 3, 1);
    finish_load();
    add_req(1, 0, 2, 14'h0000, 1'b0);
    add_req(1, 0, 2, 14'h0000, 1'b1);
    run_lookups();

    // Read-only descriptor; last in-range KB and size >= 64
    restart(1'b0);
    send_ram(5, 32'hFFFF_F000, 32'h0100, 1);
    send_ram(6, 32'h0000_0400, 8, 0);
    send_blk(3, 3, 3, 5, 3, 31, 15, 1);
    send_blk(2, 1, 0, 6, 0, 1, 9, 0);
    finish_load();
    add_req(3, 3, 3, 14'h3FFF, 1'b1);
    add_req(3, 3, 3, 14'h3FFF, 1'b0);
    add_req(2, 1, 0, 14'h1FFF, 1'b1);
    add_req(2, 1, 0, 14'h2000, 1'b0);
    run_lookups();

    // Bad tag, then bad block index, then bad ref index
    restart(1'b0);
    send_byte(8'h05);
    chk("bad_tag_error", 32'(bus.cfg_error), 32'd1);
    send_byte(8'hFF);
    chk("bad_tag_tv", 32'(bus.table_valid), 32'd0);
    add_req(1, 0, 2, 14'h0123, 1'b1);
    run_lookups();
    restart(1'b0);
    send_byte(8'h01); send_byte(8'h40); send_byte(8'h30); send_byte(8'h06);
    chk("blk_idx_pending", 32'(bus.cfg_error), 32'd0);
    send_byte(8'h30);
    chk("blk_idx_error", 32'(bus.cfg_error), 32'd1);
    restart(1'b0);
    send_ram(16, 32'h1234_5678, 4, 0);
    chk("ram_idx_error", 32'(bus.cfg_error), 32'd1);

    // Random tables and back-to-back lookups
    restart(1'b0);
    for (int r = 0; r < NR; r++) send_ram(r, $urandom(), $urandom_range(0, 80), $urandom_range(0, 1));
    for (int b = 0; b < 24; b++)
      send_blk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
               $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 1));
    finish_load();
    add_req(0, 0, 0, 14'h0010, 1'b0);
    add_req(0, 0, 1, 14'h0020, 1'b0);
    add_req(0, 0, 2, 14'h0030, 1'b1);
    add_req(0, 0, 3, 14'h0040, 1'b0);
    for (int q = 0; q < 40; q++) begin
      idx = ($urandom_range(0, 1) == 1) ? loaded[$urandom_range(0, loaded.size() - 1)] : $urandom_range(0, 63);
      add_req(idx / 16, (idx / 4) % 4, idx % 4, $urandom_range(0, 16383), 1'($urandom_range(0, 1)));
    end
    run_lookups();

    // Abort mid RAM record, reload with only the end tag
    restart(1'b0);
    send_ram(3, 32'h0010_0000, 32, 0);
    send_blk(1, 0, 2, 3, 1, 6, 3, 0);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
    restart(1'b1);
    finish_load();
    add_req(1, 0, 2, 14'h0123, 1'b0);
    add_req(0, 0, 0, 14'h0000, 1'b1);
    run_lookups();

    // Reset in the middle of a block record
    restart(1'b0);
    send_byte(8'h01); send_byte(8'h06);
    rst_n = 1'b0;
    tick();
    chk("midrst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_idle_ready", 32'(bus.cfg_ready), 32'd0);
    chk("midrst_tv", 32'(bus.table_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
